// File: rtl/game_monitor.sv
`default_nettype none
// ============================================================================
// Module      : game_monitor
// Description : Game-rule controller. Checks the bird against the bar grid
//               produced by the environment, scores bars passed, advances the
//               level when the bird reaches the win line, and drives the
//               environment's pause/level inputs plus a bird respawn pulse.
// Ports       :
//    clkgame     in   1   game clock (same domain as the environment clock)
//    rst_n       in   1   asynchronous active-low reset
//    start       in   1   single-cycle debounced button pulse
//    bird_x      in  10   bird left edge
//    bird_y      in  10   bird top edge
//    bar_pos_bus in  80   bar k top-of-opening in bits [10k+9:10k]
//    bar_op_bus  in  80   bar k opening height, same packing
//    pause       out  1   freeze the environment
//    level       out 10   current level (1..1023)
//    score       out  8   bars passed, saturating at 255
//    game_over   out  1   high while in OVER
//    respawn     out  1   one-cycle pulse to re-home the bird
// Revision    : 1.0 - initial release
// ============================================================================
module game_monitor #(
   parameter int unsigned BAR_X0      = 80,
   parameter int unsigned BAR_PITCH   = 80,
   parameter int unsigned BAR_W       = 20,
   parameter int unsigned BIRD_W      = 16,
   parameter int unsigned BIRD_H      = 16,
   parameter int unsigned SCREEN_H    = 480,
   parameter int unsigned WIN_X       = 600,
   parameter logic [7:0]  ACTIVE_MASK = 8'b0111_1110
) (
   input  logic        clkgame,
   input  logic        rst_n,
   input  logic        start,
   input  logic [9:0]  bird_x,
   input  logic [9:0]  bird_y,
   input  logic [79:0] bar_pos_bus,
   input  logic [79:0] bar_op_bus,
   output logic        pause,
   output logic [9:0]  level,
   output logic [7:0]  score,
   output logic        game_over,
   output logic        respawn
);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_PLAY  = 2'd1;
   localparam logic [1:0] c_ST_CLEAR = 2'd2;
   localparam logic [1:0] c_ST_OVER  = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic        r_pause;
   logic [9:0]  r_level;
   logic [7:0]  r_score;
   logic        r_game_over;
   logic        r_respawn;
   logic [7:0]  r_passed;
   logic        r_hit;
   logic        r_win;

   logic [11:0] w_bx;
   logic [11:0] w_by;
   logic [7:0]  w_overlap;
   logic [7:0]  w_safe;
   logic [7:0]  w_cross;
   logic        w_floor;
   logic        w_hit_c;
   logic        w_win_c;
   logic        w_in_play;
   logic [7:0]  w_new;
   logic [3:0]  w_new_cnt;
   logic [8:0]  w_score_sum;
   logic [7:0]  w_score_sat;
   logic [9:0]  w_level_inc;
   logic        w_enter_clear;
   logic        w_enter_idle;

   // All geometry is evaluated in 12 bits so sums such as pos+op never wrap.
   assign w_bx = {2'b00, bird_x};
   assign w_by = {2'b00, bird_y};

   generate
      for (genvar k = 0; k < 8; k++) begin : g_bar
         localparam logic [11:0] c_LEFT  = 12'(BAR_X0 + k * BAR_PITCH);
         localparam logic [11:0] c_RIGHT = 12'(BAR_X0 + k * BAR_PITCH + BAR_W);

         logic [11:0] w_pos;
         logic [11:0] w_gap_end;

         assign w_pos       = {2'b00, bar_pos_bus[10*k +: 10]};
         assign w_gap_end   = w_pos + {2'b00, bar_op_bus[10*k +: 10]};
         assign w_overlap[k] = (w_bx + 12'(BIRD_W) > c_LEFT) && (w_bx < c_RIGHT);
         assign w_safe[k]    = (w_by >= w_pos) && (w_by + 12'(BIRD_H) <= w_gap_end);
         assign w_cross[k]   = (w_bx >= c_RIGHT);
      end
   endgenerate

   assign w_floor   = (w_by + 12'(BIRD_H) > 12'(SCREEN_H));
   assign w_hit_c   = w_floor || (|(ACTIVE_MASK & w_overlap & ~w_safe));
   assign w_win_c   = (w_bx >= 12'(WIN_X));
   assign w_in_play = (r_state == c_ST_PLAY);

   // Bars crossed for the first time this cycle; nothing scores on a hit.
   assign w_new = (w_in_play && !w_hit_c) ? (ACTIVE_MASK & w_cross & ~r_passed) : 8'h00;

   always_comb begin
      w_new_cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         w_new_cnt = w_new_cnt + {3'b000, w_new[i]};
      end
   end

   assign w_score_sum = {1'b0, r_score} + {5'b00000, w_new_cnt};
   assign w_score_sat = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

   // Level 0 is reserved, so the counter wraps from 1023 back to 1.
   assign w_level_inc = (r_level == 10'd1023) ? 10'd1 : (r_level + 10'd1);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  if (start) w_state_nxt = c_ST_PLAY;
         c_ST_PLAY: begin
            // A collision takes precedence over reaching the win line.
            if (r_hit)      w_state_nxt = c_ST_OVER;
            else if (r_win) w_state_nxt = c_ST_CLEAR;
         end
         c_ST_CLEAR: if (start) w_state_nxt = c_ST_PLAY;
         c_ST_OVER:  if (start) w_state_nxt = c_ST_IDLE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   assign w_enter_clear = (r_state == c_ST_PLAY) && (w_state_nxt == c_ST_CLEAR);
   assign w_enter_idle  = (r_state == c_ST_OVER) && (w_state_nxt == c_ST_IDLE);

   always_ff @(posedge clkgame or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_ST_IDLE;
         r_pause     <= 1'b1;
         r_level     <= 10'd1;
         r_score     <= 8'd0;
         r_game_over <= 1'b0;
         r_respawn   <= 1'b0;
         r_passed    <= 8'h00;
         r_hit       <= 1'b0;
         r_win       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pause     <= (w_state_nxt != c_ST_PLAY);
         r_game_over <= (w_state_nxt == c_ST_OVER);
         r_respawn   <= w_enter_clear || w_enter_idle;
         r_hit       <= w_in_play && w_hit_c;
         r_win       <= w_in_play && w_win_c;

         if (w_enter_idle) begin
            r_level  <= 10'd1;
            r_score  <= 8'd0;
            r_passed <= 8'h00;
         end else begin
            r_score <= w_score_sat;
            if (w_enter_clear) begin
               r_level  <= w_level_inc;
               r_passed <= 8'h00;
            end else begin
               r_passed <= r_passed | w_new;
            end
         end
      end
   end

   assign pause     = r_pause;
   assign level     = r_level;
   assign score     = r_score;
   assign game_over = r_game_over;
   assign respawn   = r_respawn;

endmodule
`default_nettype wire

// File: tb/tb_game_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_monitor
// Description : Self-checking bench for game_monitor. A behavioural model of
//               the game rules predicts the registered outputs for every
//               cycle; predictions are queued when stimulus is applied and
//               popped and compared after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_monitor;

   logic        clkgame = 1'b0;
   logic        rst_n   = 1'b0;
   logic        start   = 1'b0;
   logic [9:0]  bird_x  = '0;
   logic [9:0]  bird_y  = '0;
   logic [79:0] bar_pos_bus = '0;
   logic [79:0] bar_op_bus  = '0;
   logic        pause;
   logic [9:0]  level;
   logic [7:0]  score;
   logic        game_over;
   logic        respawn;

   typedef struct {
      logic       pause;
      logic [9:0] level;
      logic [7:0] score;
      logic       game_over;
      logic       respawn;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   // Reference model state: 0 IDLE, 1 PLAY, 2 CLEAR, 3 OVER
   int         m_st     = 0;
   int         m_level  = 1;
   int         m_score  = 0;
   logic [7:0] m_passed = '0;
   bit         m_hit    = 0;
   bit         m_win    = 0;
   logic [7:0] mask     = 8'b0111_1110;

   game_monitor dut (
      .clkgame     (clkgame),
      .rst_n       (rst_n),
      .start       (start),
      .bird_x      (bird_x),
      .bird_y      (bird_y),
      .bar_pos_bus (bar_pos_bus),
      .bar_op_bus  (bar_op_bus),
      .pause       (pause),
      .level       (level),
      .score       (score),
      .game_over   (game_over),
      .respawn     (respawn)
   );

   always #5 clkgame = ~clkgame;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input int got, input int exp_v);
      n_total++;
      if (got != exp_v) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp_v, $time);
      end
   endtask

   task automatic set_bars(input int pos, input int op);
      for (int k = 0; k < 8; k++) begin
         bar_pos_bus[10*k +: 10] = 10'(pos);
         bar_op_bus[10*k +: 10]  = 10'(op);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_level = 1; m_score = 0; m_passed = '0; m_hit = 0; m_win = 0;
   endtask

   // Predict the outputs after the next edge, clock it, then compare.
   task automatic cycle(input string tag);
      exp_t       e;
      int         bx, by, nst, nlev, nsc;
      bit         hitc, winc, resp;
      logic [7:0] npass;
      bx   = int'(bird_x);
      by   = int'(bird_y);
      hitc = (by + 16 > 480);
      winc = (bx >= 600);
      for (int k = 0; k < 8; k++) begin
         int left, pos, op;
         left = 80 + 80 * k;
         pos  = int'(bar_pos_bus[10*k +: 10]);
         op   = int'(bar_op_bus[10*k +: 10]);
         if (mask[k] && (bx + 16 > left) && (bx < left + 20) &&
             !((by >= pos) && (by + 16 <= pos + op)))
            hitc = 1;
      end
      nst = m_st;
      case (m_st)
         0: if (start) nst = 1;
         1: if (m_hit) nst = 3; else if (m_win) nst = 2;
         2: if (start) nst = 1;
         default: if (start) nst = 0;
      endcase
      npass = m_passed;
      nsc   = m_score;
      if (m_st == 1 && !hitc) begin
         for (int k = 0; k < 8; k++) begin
            if (mask[k] && (bx >= 80 + 80 * k + 20) && !m_passed[k]) begin
               npass[k] = 1'b1;
               nsc++;
            end
         end
      end
      if (nsc > 255) nsc = 255;
      nlev = m_level;
      resp = 0;
      if (m_st == 1 && nst == 2) begin
         nlev = (m_level == 1023) ? 1 : m_level + 1;
         npass = '0;
         resp = 1;
      end
      if (m_st == 3 && nst == 0) begin
         nlev = 1; nsc = 0; npass = '0; resp = 1;
      end
      m_hit = (m_st == 1) && hitc;
      m_win = (m_st == 1) && winc;
      m_st = nst; m_level = nlev; m_score = nsc; m_passed = npass;
      e.pause     = (nst != 1);
      e.level     = 10'(nlev);
      e.score     = 8'(nsc);
      e.game_over = (nst == 3);
      e.respawn   = resp;
      exp_q.push_back(e);

      @(posedge clkgame);
      #1;
      e = exp_q.pop_front();
      check({tag, ".pause"},     int'(pause),     int'(e.pause));
      check({tag, ".level"},     int'(level),     int'(e.level));
      check({tag, ".score"},     int'(score),     int'(e.score));
      check({tag, ".game_over"}, int'(game_over), int'(e.game_over));
      check({tag, ".respawn"},   int'(respawn),   int'(e.respawn));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".pause"},     int'(pause),     1);
      check({tag, ".level"},     int'(level),     1);
      check({tag, ".score"},     int'(score),     0);
      check({tag, ".game_over"}, int'(game_over), 0);
      check({tag, ".respawn"},   int'(respawn),   0);
   endtask

   initial begin
      // Power-on reset
      #12;
      check_reset_values("por");
      rst_n = 1'b1;
      #4;

      // Sweep through the gap centres of bars 1..6, then win the level.
      set_bars(200, 150);
      bird_y = 10'd260;
      bird_x = 10'd100;
      start  = 1'b1;
      cycle("start");
      start  = 1'b0;
      for (int x = 100; x <= 600; x += 4) begin
         bird_x = 10'(x);
         start  = (x == 300);    // start is ignored while playing
         cycle("sweep");
      end
      start = 1'b0;
      repeat (3) cycle("clear");
      check("sweep.final_score", int'(score), 6);
      check("sweep.final_level", int'(level), 2);
      check("sweep.clear_pause", int'(pause), 1);

      // Multi-bar jump: 170 -> 400 crosses bars 1, 2 and 3 at once.
      bird_x = 10'd170;
      start  = 1'b1;
      cycle("resume");
      start  = 1'b0;
      repeat (2) cycle("pre_jump");
      bird_x = 10'd400;
      cycle("jump");
      check("jump.score", int'(score), 9);
      cycle("post_jump");

      // Asynchronous reset in the middle of a game.
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_values("midreset");
      model_reset();
      #2;
      rst_n = 1'b1;

      // Bar 1 collision: in the gap is safe, above it is a hit.
      set_bars(240, 150);
      bird_x = 10'd150;
      bird_y = 10'd250;
      start  = 1'b1;
      cycle("play2");
      start  = 1'b0;
      repeat (4) cycle("safe");
      check("safe.pause", int'(pause), 0);
      bird_y = 10'd230;
      cycle("hit_n");
      check("hit_n.pause", int'(pause), 0);
      cycle("hit_n1");
      check("hit_n1.game_over", int'(game_over), 1);
      cycle("over");

      // Back to IDLE, then floor test with a gap reaching past the bottom.
      start = 1'b1;
      cycle("to_idle");
      start = 1'b0;
      cycle("idle");
      check("idle.score", int'(score), 0);
      set_bars(240, 300);
      bird_x = 10'd400;
      bird_y = 10'd464;
      start  = 1'b1;
      cycle("play3");
      start  = 1'b0;
      repeat (4) cycle("low_ok");
      check("low_ok.pause", int'(pause), 0);
      bird_y = 10'd470;
      repeat (2) cycle("floor");
      check("floor.game_over", int'(game_over), 1);

      // Many levels: score saturation and the 1023 -> 1 level wrap.
      start = 1'b1;
      cycle("to_idle2");
      start = 1'b0;
      cycle("idle2");
      set_bars(200, 150);
      bird_y = 10'd260;
      for (int lv = 1; lv <= 1023; lv++) begin
         bird_x = 10'd0;
         start  = 1'b1;
         cycle("lv_start");
         start  = 1'b0;
         cycle("lv_play");
         bird_x = 10'd600;
         cycle("lv_win");
         cycle("lv_clear");
         if (lv == 42)   check("sat.score252",  int'(score), 252);
         if (lv == 43)   check("sat.score255",  int'(score), 255);
         if (lv == 1022) check("wrap.level1023", int'(level), 1023);
         if (lv == 1023) check("wrap.level1",   int'(level), 1);
      end

      // Hit and win in the same cycle: collision wins.
      bird_x = 10'd0;
      bird_y = 10'd260;
      start  = 1'b1;
      cycle("final_start");
      start  = 1'b0;
      cycle("final_play");
      bird_x = 10'd600;
      bird_y = 10'd470;
      repeat (2) cycle("hit_win");
      check("hit_win.game_over", int'(game_over), 1);
      check("hit_win.score",     int'(score), 255);
      start = 1'b1;
      cycle("final_idle");
      start = 1'b0;
      cycle("final_hold");
      check("final.level", int'(level), 1);
      check("final.score", int'(score), 0);
      check("final.game_over", int'(game_over), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
